if_resp_discard_tracker: RTL and testbench

Tracks instruction-SRAM requests that have been accepted but not yet answered. On a front-end redirect (exception, ertn or branch), it marks every such request as wrong-path and flags each matching `data_ok` response for discard. This generalises the fixed 0/1/2 cancel tracking to up to `MAX_OUT` outstanding requests. It sits between the IF stage and the instruction SRAM-like interface, gates new requests and kills a stale IF-buffered instruction.

---
 rtl/if_resp_discard_tracker.sv | 83 ++++++++
 tb/tb_if_resp_discard_tracker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/if_resp_discard_tracker.sv
// Tracks accepted-but-unanswered instruction fetches and marks those in flight at a
// redirect as wrong-path, so their data_ok responses are dropped in arrival order.
module if_resp_discard_tracker #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_fire,
  input  logic              resp_fire,
  input  logic              if_buf_valid,
  input  logic              if_to_id_fire,
  output logic              resp_discard,
  output logic              if_buf_kill,
  output logic              req_allow,
  output logic [CNT_W-1:0]  outstanding,
  output logic [CNT_W-1:0]  discard_cnt,
  output logic              drained,
  output logic              proto_err,
  output logic [PERF_W-1:0] discard_total
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic              proto_err_q, proto_err_d;
  logic [PERF_W-1:0] total_q, total_d;
  logic              full, empty, inc, dec;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    if (v == {PERF_W{1'b1}}) return v;
    return v + PERF_W'(1);
  endfunction

  always_comb begin
    full  = (outstanding_q == MAX_C);
    empty = (outstanding_q == '0);
    // A request at full is only absorbed when a response frees a slot the same cycle.
    inc   = req_fire & ~(full & ~resp_fire);
    dec   = resp_fire & ~empty;

    outstanding_d = outstanding_q;
    if (inc && !dec)      outstanding_d = outstanding_q + ONE_C;
    else if (!inc && dec) outstanding_d = outstanding_q - ONE_C;

    // Everything still in flight after this edge predates the redirect.
    discard_d = discard_q;
    if (flush)                          discard_d = outstanding_d;
    else if (resp_fire && discard_q != '0) discard_d = discard_q - ONE_C;

    resp_discard = resp_fire & (flush | (discard_q != '0));
    if_buf_kill  = flush & if_buf_valid & ~if_to_id_fire;

    proto_err_d = proto_err_q | (req_fire & full & ~resp_fire) | (resp_fire & empty);
    total_d     = resp_discard ? sat_inc(total_q) : total_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      discard_q     <= '0;
      proto_err_q   <= 1'b0;
      total_q       <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      proto_err_q   <= proto_err_d;
      total_q       <= total_d;
    end
  end

  assign outstanding   = outstanding_q;
  assign discard_cnt   = discard_q;
  assign drained       = (discard_q == '0);
  assign req_allow     = (outstanding_q != MAX_C);
  assign proto_err     = proto_err_q;
  assign discard_total = total_q;

endmodule

// File: tb/tb_if_resp_discard_tracker.sv
// Bench for if_resp_discard_tracker: directed vector table, reset corner sequence,
// and random traffic against a queue-of-requests reference model.
module tb_if_resp_discard_tracker;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 3;
  localparam int PERF_W  = 4;

  logic clk = 1'b0;
  logic rst, flush, req_fire, resp_fire, if_buf_valid, if_to_id_fire;
  logic resp_discard, if_buf_kill, req_allow, drained, proto_err;
  logic [CNT_W-1:0]  outstanding, discard_cnt;
  logic [PERF_W-1:0] discard_total;

  if_resp_discard_tracker #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_fire(req_fire), .resp_fire(resp_fire),
    .if_buf_valid(if_buf_valid), .if_to_id_fire(if_to_id_fire),
    .resp_discard(resp_discard), .if_buf_kill(if_buf_kill), .req_allow(req_allow),
    .outstanding(outstanding), .discard_cnt(discard_cnt), .drained(drained),
    .proto_err(proto_err), .discard_total(discard_total)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one entry per accepted request, 1 = wrong-path.
  bit m_q[$];
  int m_err, m_tot;

  function automatic int m_ones();
    int n = 0;
    foreach (m_q[i]) n += m_q[i];
    return n;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_err = 0;
    m_tot = 0;
  endtask

  task automatic m_step(input logic fl, input logic rq, input logic rs);
    int sz = m_q.size();
    bit dis = rs & (fl | (m_ones() != 0));
    if (rq && sz == MAX_OUT && !rs) m_err = 1;
    if (rs && sz == 0) m_err = 1;
    if (rs && sz > 0) void'(m_q.pop_front());
    if (rq && !(sz == MAX_OUT && !rs)) m_q.push_back(1'b0);
    if (fl) foreach (m_q[i]) m_q[i] = 1'b1;
    if (dis && m_tot < (1 << PERF_W) - 1) m_tot++;
  endtask

  task automatic drive(input logic r, input logic fl, input logic rq, input logic rs,
                       input logic bv, input logic tf);
    rst = r; flush = fl; req_fire = rq; resp_fire = rs;
    if_buf_valid = bv; if_to_id_fire = tf;
  endtask

  task automatic chk_regs(input string tag, input int o, input int dc, input int er, input int tt);
    chk({tag, ".outstanding"}, 32'(outstanding), 32'(o));
    chk({tag, ".discard_cnt"}, 32'(discard_cnt), 32'(dc));
    chk({tag, ".req_allow"}, 32'(req_allow), 32'(o != MAX_OUT));
    chk({tag, ".drained"}, 32'(drained), 32'(dc == 0));
    chk({tag, ".proto_err"}, 32'(proto_err), 32'(er));
    chk({tag, ".discard_total"}, 32'(discard_total), 32'(tt));
  endtask

  typedef struct {
    logic fl, rq, rs, bv, tf;
    logic dis, kill;
    int   out, dc, err, tot;
  } vec_t;

  function automatic vec_t mk(input logic fl, rq, rs, bv, tf, dis, kill,
                              input int out, dc, err, tot);
    vec_t v;
    v.fl = fl; v.rq = rq; v.rs = rs; v.bv = bv; v.tf = tf;
    v.dis = dis; v.kill = kill; v.out = out; v.dc = dc; v.err = err; v.tot = tot;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    //                   fl rq rs bv tf dis kill out dc err tot
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 4, 4, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 3, 3, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 2, 2, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 5));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 0, 0, 5));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4, 0, 0, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 0, 1, 5));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3, 0, 1, 5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3, 3, 1, 5));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 3, 3, 1, 6));

    // Reset state
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst.resp_discard", 32'(resp_discard), 0);
    chk("rst.if_buf_kill", 32'(if_buf_kill), 0);
    chk_regs("rst", 0, 0, 0, 0);

    // Directed table
    foreach (tbl[i]) begin
      drive(0, tbl[i].fl, tbl[i].rq, tbl[i].rs, tbl[i].bv, tbl[i].tf);
      #2;
      chk($sformatf("vec%0d.resp_discard", i), 32'(resp_discard), 32'(tbl[i].dis));
      chk($sformatf("vec%0d.if_buf_kill", i), 32'(if_buf_kill), 32'(tbl[i].kill));
      @(posedge clk);
      #1;
      chk_regs($sformatf("vec%0d", i), tbl[i].out, tbl[i].dc, tbl[i].err, tbl[i].tot);
    end

    // Mid-operation reset with wrong-path requests in flight
    drive(1, 0, 0, 0, 0, 0); @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 0); @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 0); @(posedge clk); #1;
    drive(0, 1, 0, 0, 0, 0); @(posedge clk); #1;
    chk_regs("midrst.pre", 2, 2, 0, 0);
    drive(1, 0, 0, 0, 0, 0); @(posedge clk); #1;
    chk_regs("midrst.post", 0, 0, 0, 0);

    // Random traffic against the model
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      logic fl, rq, rs, bv, tf;
      if ($urandom_range(0, 199) == 0) begin
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        m_reset();
        chk_regs("rnd.rst", 0, 0, 0, 0);
        continue;
      end
      fl = ($urandom_range(0, 7) == 0);
      rq = ($urandom_range(0, 99) < 55);
      rs = (m_q.size() == 0) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 99) < 45);
      bv = $urandom_range(0, 1);
      tf = $urandom_range(0, 1);
      drive(0, fl, rq, rs, bv, tf);
      #2;
      chk("rnd.resp_discard", 32'(resp_discard), 32'(rs & (fl | (m_ones() != 0))));
      chk("rnd.if_buf_kill", 32'(if_buf_kill), 32'(fl & bv & ~tf));
      m_step(fl, rq, rs);
      @(posedge clk); #1;
      chk_regs("rnd", m_q.size(), m_ones(), m_err, m_tot);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
